// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer: owns the PC and IR, fetches one instruction
// word per instruction over a req/ack port and strobes the decoder phases.
module control_sequencer #(
    parameter int unsigned          PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                mem_rd,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic                mem_ack,
    input  logic [7:0]          mem_data,
    output logic [7:0]          ir,
    output logic                decode,
    output logic                execute,
    input  logic                exec_stall,
    input  logic                jump_take,
    input  logic [PC_WIDTH-1:0] jump_addr,
    output logic [PC_WIDTH-1:0] pc,
    output logic                busy
);

    localparam int unsigned IR_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DECODE  = 2'd2,
        ST_EXECUTE = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [PC_WIDTH-1:0]   pc_next;
    logic [IR_WIDTH-1:0]   ir_next;

    // State, PC/IR and strobes; strobes are registered from the next state so
    // they line up with the state they describe without any input-to-output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            pc      <= RESET_PC;
            ir      <= '0;
            mem_rd  <= 1'b0;
            decode  <= 1'b0;
            execute <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            ir      <= ir_next;
            mem_rd  <= (state_next == ST_FETCH);
            decode  <= (state_next == ST_DECODE);
            execute <= (state_next == ST_EXECUTE);
            busy    <= (state_next != ST_IDLE);
        end
    end

    // Next-state, PC and IR update.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        unique case (state)
            ST_IDLE: begin
                if (run) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    ir_next    = mem_data;
                    pc_next    = pc + PC_WIDTH'(1);
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_next = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                // Jump target and run are only honoured on the final, unstalled cycle.
                if (!exec_stall) begin
                    if (jump_take) pc_next = jump_addr;
                    state_next = run ? ST_FETCH : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign mem_addr = pc;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised self-checking bench for control_sequencer; expectations come from
// a per-instruction model (PC/IR arithmetic and 3+N+S cycle timing).
module tb_control_sequencer;

    logic       clk;
    logic       reset;
    logic       run;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic [7:0] ir;
    logic       decode;
    logic       execute;
    logic       exec_stall;
    logic       jump_take;
    logic [7:0] jump_addr;
    logic [7:0] pc;
    logic       busy;

    int checks;
    int failures;

    logic [7:0] mem [256];
    logic [7:0] exp_pc;
    logic [7:0] exp_ir;

    control_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .ir         (ir),
        .decode     (decode),
        .execute    (execute),
        .exec_stall (exec_stall),
        .jump_take  (jump_take),
        .jump_addr  (jump_addr),
        .pc         (pc),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One instruction starting with the DUT in FETCH at the current negedge.
    // Ends at the negedge of the cycle after the final EXECUTE cycle.
    task automatic run_instr(input int wait_n, input int stall_s, input bit jt,
                             input logic [7:0] ja, input bit stall_jt,
                             input bit run_after, input bit stray);
        for (int k = 0; k <= wait_n; k++) begin
            checks++;
            if (mem_rd !== 1'b1 || mem_addr !== exp_pc || decode !== 1'b0 ||
                execute !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL fetch k=%0d: mem_rd=%b mem_addr=%h decode=%b execute=%b busy=%b, required 1 %h 0 0 1",
                         k, mem_rd, mem_addr, decode, execute, busy, exp_pc);
            end
            checks++;
            if (pc !== exp_pc || ir !== exp_ir) begin
                failures++;
                $display("FAIL fetch_hold k=%0d: pc=%h ir=%h, required %h %h", k, pc, ir, exp_pc, exp_ir);
            end
            mem_ack    = (k == wait_n);
            mem_data   = mem[exp_pc];
            run        = 1'($urandom);
            jump_take  = 1'($urandom);
            jump_addr  = 8'($urandom);
            exec_stall = 1'($urandom);
            @(negedge clk);
        end
        exp_ir = mem[exp_pc];
        exp_pc = exp_pc + 8'd1;

        checks++;
        if (decode !== 1'b1 || execute !== 1'b0 || mem_rd !== 1'b0 || busy !== 1'b1 ||
            ir !== exp_ir || pc !== exp_pc) begin
            failures++;
            $display("FAIL decode: decode=%b execute=%b mem_rd=%b busy=%b ir=%h pc=%h, required 1 0 0 1 %h %h",
                     decode, execute, mem_rd, busy, ir, pc, exp_ir, exp_pc);
        end
        mem_ack    = stray;
        mem_data   = 8'($urandom);
        jump_take  = 1'($urandom);
        jump_addr  = 8'($urandom);
        exec_stall = 1'($urandom);
        @(negedge clk);

        for (int s = 0; s <= stall_s; s++) begin
            checks++;
            if (execute !== 1'b1 || decode !== 1'b0 || mem_rd !== 1'b0 || busy !== 1'b1 ||
                ir !== exp_ir || pc !== exp_pc) begin
                failures++;
                $display("FAIL execute s=%0d: execute=%b decode=%b mem_rd=%b busy=%b ir=%h pc=%h, required 1 0 0 1 %h %h",
                         s, execute, decode, mem_rd, busy, ir, pc, exp_ir, exp_pc);
            end
            exec_stall = (s != stall_s);
            jump_take  = (s == stall_s) ? jt : stall_jt;
            jump_addr  = ja;
            run        = (s == stall_s) ? run_after : 1'($urandom);
            mem_ack    = stray;
            mem_data   = 8'($urandom);
            @(negedge clk);
        end
        if (jt) exp_pc = ja;
        mem_ack    = 1'b0;
        exec_stall = 1'b0;
        jump_take  = 1'b0;

        checks++;
        if (run_after) begin
            if (mem_rd !== 1'b1 || busy !== 1'b1 || mem_addr !== exp_pc || execute !== 1'b0 || ir !== exp_ir) begin
                failures++;
                $display("FAIL next_fetch: mem_rd=%b busy=%b mem_addr=%h execute=%b ir=%h, required 1 1 %h 0 %h",
                         mem_rd, busy, mem_addr, execute, ir, exp_pc, exp_ir);
            end
        end else begin
            if (mem_rd !== 1'b0 || busy !== 1'b0 || decode !== 1'b0 || execute !== 1'b0 ||
                pc !== exp_pc || ir !== exp_ir) begin
                failures++;
                $display("FAIL to_idle: mem_rd=%b busy=%b decode=%b execute=%b pc=%h ir=%h, required 0 0 0 0 %h %h",
                         mem_rd, busy, decode, execute, pc, ir, exp_pc, exp_ir);
            end
        end
    endtask

    // From IDLE: hold with run low and stray acks, then start fetching.
    task automatic test_idle;
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ack  = 1'b1;
            mem_data = 8'($urandom);
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || mem_rd !== 1'b0 || pc !== exp_pc || ir !== exp_ir) begin
                failures++;
                $display("FAIL idle_hold: busy=%b mem_rd=%b pc=%h ir=%h, required 0 0 %h %h",
                         busy, mem_rd, pc, ir, exp_pc, exp_ir);
            end
        end
        mem_ack = 1'b0;
        run     = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        run      = 1'b1;
        mem_ack  = 1'b1;
        mem_data = 8'h5A;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pc !== 8'h00 || ir !== 8'h00 || mem_rd !== 1'b0 || decode !== 1'b0 ||
            execute !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset: pc=%h ir=%h mem_rd=%b decode=%b execute=%b busy=%b, required 00 00 0 0 0 0",
                     pc, ir, mem_rd, decode, execute, busy);
        end
        reset   = 1'b0;
        mem_ack = 1'b0;
        exp_pc  = 8'h00;
        exp_ir  = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        mem[0] = 8'h10;
        mem[1] = 8'h20;
        run_instr(0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        run_instr(0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_wait_states;
        run_instr(3, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        run_instr(2, 1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_jump_stall;
        run_instr(0, 2, 1'b0, 8'h42, 1'b1, 1'b1, 1'b0);
        run_instr(0, 2, 1'b1, 8'h42, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap;
        mem[8'hFF] = 8'hC3;
        run_instr(1, 0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        run_instr(0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_run_drop;
        run_instr(2, 1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        test_idle();
    endtask

    task automatic test_reset_mid_fetch;
        reset    = 1'b1;
        mem_ack  = 1'b1;
        mem_data = 8'hAB;
        @(negedge clk);
        checks++;
        if (ir !== 8'h00 || pc !== 8'h00 || mem_rd !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_fetch: ir=%h pc=%h mem_rd=%b busy=%b, required 00 00 0 0",
                     ir, pc, mem_rd, busy);
        end
        reset   = 1'b0;
        mem_ack = 1'b0;
        exp_pc  = 8'h00;
        exp_ir  = 8'h00;
        test_idle();
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            bit ra;
            ra = ($urandom_range(0, 3) != 0);
            run_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'($urandom),
                      8'($urandom), 1'($urandom), ra, 1'($urandom));
            if (!ra) test_idle();
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        run        = 1'b0;
        mem_ack    = 1'b0;
        mem_data   = 8'h00;
        exec_stall = 1'b0;
        jump_take  = 1'b0;
        jump_addr  = 8'h00;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        exp_pc = 8'h00;
        exp_ir = 8'h00;
        @(negedge clk);

        test_reset();
        test_back_to_back();
        test_wait_states();
        test_jump_stall();
        test_wrap();
        test_run_drop();
        test_reset_mid_fetch();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
